// File: rtl/kbd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : kbd_pkg
// Brief    : Shared constants and RX state type for the PS/2 keyboard responder.
// Revision : 1.0 - initial release
// ============================================================================
package kbd_pkg;

    localparam logic [11:0] c_BASE_HI    = 12'h003;

    localparam logic [1:0]  c_REG_DATA   = 2'd0;
    localparam logic [1:0]  c_REG_STATUS = 2'd1;

    localparam int          c_ST_NEMPTY  = 0;
    localparam int          c_ST_OVF     = 1;
    localparam int          c_ST_PERR    = 2;
    localparam int          c_ST_FERR    = 3;
    localparam int          c_ST_TOUT    = 4;
    localparam int          c_ST_CNT_LSB = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/ps2_rx_frame.sv
`default_nettype none
// ============================================================================
// Module   : ps2_rx_frame
// Brief    : PS/2 device-to-host frame receiver (sync, edge detect, frame FSM).
//            Optional inactivity abort enabled by defining PS2_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_rx_frame
    import kbd_pkg::*;
#(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_vld,
    output logic [7:0] rx_byte,
    output logic       perr,
    output logic       ferr,
    output logic       tout
);

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("ps2_rx_frame: TIMEOUT_CYC must be >= 1");
    end

    logic [1:0] r_clk_s;
    logic [1:0] r_dat_s;
    logic       r_clk_prev;
    logic       w_sample;
    logic       w_bit;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_clk_s    <= 2'b11;
            r_dat_s    <= 2'b11;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_s    <= {r_clk_s[0], ps2_clk};
            r_dat_s    <= {r_dat_s[0], ps2_data};
            r_clk_prev <= r_clk_s[1];
        end
    end

    // Device changes data on the rising edge, so the falling edge is the stable sample point.
    assign w_sample = r_clk_prev & ~r_clk_s[1];
    assign w_bit    = r_dat_s[1];

    rx_state_t  r_state;
    logic [2:0] r_bitcnt;
    logic [7:0] r_shift;
    logic       r_perr_pend;

`ifdef PS2_TIMEOUT_EN
    localparam int c_TCNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [c_TCNT_W-1:0] r_tcnt;
`else
    assign tout = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_bitcnt    <= 3'd0;
            r_shift     <= 8'h00;
            r_perr_pend <= 1'b0;
            byte_vld    <= 1'b0;
            rx_byte     <= 8'h00;
            perr        <= 1'b0;
            ferr        <= 1'b0;
`ifdef PS2_TIMEOUT_EN
            tout        <= 1'b0;
            r_tcnt      <= c_TCNT_W'(TIMEOUT_CYC);
`endif
        end else begin
            byte_vld <= 1'b0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
`ifdef PS2_TIMEOUT_EN
            tout     <= 1'b0;
`endif
            if (w_sample) begin
`ifdef PS2_TIMEOUT_EN
                r_tcnt <= c_TCNT_W'(TIMEOUT_CYC);
`endif
                case (r_state)
                    IDLE: begin
                        if (!w_bit) begin
                            r_state  <= DATA;
                            r_bitcnt <= 3'd0;
                        end
                    end
                    DATA: begin
                        r_shift  <= {w_bit, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            r_state <= PARITY;
                        end
                    end
                    PARITY: begin
                        r_perr_pend <= ~(^{r_shift, w_bit});
                        r_state     <= STOP;
                    end
                    STOP: begin
                        r_state <= IDLE;
                        if (w_bit && !r_perr_pend) begin
                            byte_vld <= 1'b1;
                            rx_byte  <= r_shift;
                        end
                        ferr <= ~w_bit;
                        perr <= r_perr_pend;
                    end
                    default: r_state <= IDLE;
                endcase
            end
`ifdef PS2_TIMEOUT_EN
            else if (r_state != IDLE) begin
                if (r_tcnt <= c_TCNT_W'(1)) begin
                    r_state <= IDLE;
                    tout    <= 1'b1;
                end else begin
                    r_tcnt <= r_tcnt - c_TCNT_W'(1);
                end
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_kbd_resp.sv
`default_nettype none
// ============================================================================
// Module   : ps2_kbd_resp
// Brief    : CPU read responder for the PS/2 keyboard: scancode FIFO plus
//            DATA/STATUS registers. Define PS2_TIMEOUT_EN for frame timeout.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_kbd_resp
    import kbd_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 16,
    parameter int          TIMEOUT_CYC = 50000,
    parameter logic [11:0] BASE_HI     = c_BASE_HI
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic [31:0] rdaddr,
    input  logic        rden,
    output logic [31:0] rddata
);

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 256 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("ps2_kbd_resp: FIFO_DEPTH must be a power of 2 in 2..256");
    end

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_AW + 1;

    logic       w_rx_vld;
    logic [7:0] w_rx_byte;
    logic       w_perr_evt;
    logic       w_ferr_evt;
    logic       w_tout_evt;

    ps2_rx_frame #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clock    (clock),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .byte_vld (w_rx_vld),
        .rx_byte  (w_rx_byte),
        .perr     (w_perr_evt),
        .ferr     (w_ferr_evt),
        .tout     (w_tout_evt)
    );

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic            r_ovf;
    logic            r_perr;
    logic            r_ferr;
    logic            r_tout;

    logic            w_sel;
    logic [1:0]      w_off;
    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_ovf_evt;
    logic            w_stat_rd;
    logic [31:0]     w_status;
    logic            w_unused;

    assign w_sel     = rden && (rdaddr[31:20] == BASE_HI);
    assign w_off     = rdaddr[3:2];
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_CW'(FIFO_DEPTH));
    assign w_pop     = w_sel && (w_off == c_REG_DATA) && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push    = w_rx_vld && (!w_full || w_pop);
    assign w_ovf_evt = w_rx_vld && w_full && !w_pop;
    assign w_stat_rd = w_sel && (w_off == c_REG_STATUS);
    assign w_unused  = ^{rdaddr[19:4], rdaddr[1:0]};

    always_comb begin
        w_status                                = 32'h0;
        w_status[c_ST_NEMPTY]                   = !w_empty;
        w_status[c_ST_OVF]                      = r_ovf;
        w_status[c_ST_PERR]                     = r_perr;
        w_status[c_ST_FERR]                     = r_ferr;
        w_status[c_ST_TOUT]                     = r_tout;
        w_status[c_ST_CNT_LSB +: 8]             = 8'(r_count);
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_rx_byte;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky flags: a STATUS read clears them, but an event in that same cycle survives.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ovf  <= 1'b0;
            r_perr <= 1'b0;
            r_ferr <= 1'b0;
            r_tout <= 1'b0;
        end else if (w_stat_rd) begin
            r_ovf  <= w_ovf_evt;
            r_perr <= w_perr_evt;
            r_ferr <= w_ferr_evt;
            r_tout <= w_tout_evt;
        end else begin
            r_ovf  <= r_ovf  | w_ovf_evt;
            r_perr <= r_perr | w_perr_evt;
            r_ferr <= r_ferr | w_ferr_evt;
            r_tout <= r_tout | w_tout_evt;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rddata <= 32'h0;
        end else if (w_sel) begin
            case (w_off)
                c_REG_DATA:   rddata <= w_empty ? 32'h0 : {24'h0, r_mem[r_rd_ptr]};
                c_REG_STATUS: rddata <= w_status;
                default:      rddata <= 32'h0;
            endcase
        end
    end

endmodule
`default_nettype wire
